// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the 800x480 panel path.
// MAX_SX/MAX_SY are also used by the colour stage for framebuffer bounds.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 40;
    localparam int VGA_H_SYNC   = 48;
    localparam int VGA_H_BP     = 88;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 13;
    localparam int VGA_V_SYNC   = 3;
    localparam int VGA_V_BP     = 32;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int MAX_SX = VGA_H_ACTIVE - 1;
    localparam int MAX_SY = VGA_V_ACTIVE - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_if.sv
// Scan-out bus between the timing generator (master) and the colour
// stage / renderer (slave), including the buffer-swap handshake.
interface vga_timing_if;
    import vga_pkg::*;

    coord_t sx;
    coord_t sy;
    logic   hsync;
    logic   vsync;
    logic   de;
    logic   frame_start;
    logic   swap_req;
    logic   swap_ack;
    logic   buf_sel;

    modport master (
        output sx, sy, hsync, vsync, de, frame_start,
        output swap_ack, buf_sel,
        input  swap_req
    );

    modport slave (
        input  sx, sy, hsync, vsync, de, frame_start,
        input  swap_ack, buf_sel,
        output swap_req
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with async active-low reset to RST_VAL.
// DEPTH=0 degenerates to a straight wire.
module vga_delay_line #(
    parameter int                 WIDTH   = 3,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused_clk;
        assign w_unused_clk = clk ^ rst_n;
        assign o_q = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= RST_VAL;
                end
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// Pixel-clock scan counters, delayed sync/de and optional double-buffer
// swap at the start of vertical blanking (macro VGA_BUFFER_SWAP_EN).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 1
) (
    input logic          clk,
    input logic          rst_n,
    vga_timing_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t C_H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t C_V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t C_HA     = coord_t'(H_ACTIVE);
    localparam coord_t C_VA     = coord_t'(V_ACTIVE);
    localparam coord_t C_HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t C_HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t C_VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t C_VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0] C_CHAIN_RST =
        {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    coord_t     r_sx;
    coord_t     r_sy;
    logic       w_h_end;
    logic       w_v_end;
    logic       w_de_raw;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [2:0] w_chain_d;
    logic [2:0] w_chain_q;

    assign w_h_end = (r_sx == C_H_LAST);
    assign w_v_end = (r_sy == C_V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (w_h_end) begin
            r_sx <= '0;
            r_sy <= w_v_end ? '0 : r_sy + 1'b1;
        end else begin
            r_sx <= r_sx + 1'b1;
        end
    end

    assign w_de_raw = (r_sx < C_HA) && (r_sy < C_VA);
    assign w_hs_raw = (r_sx >= C_HS_BEG) && (r_sx < C_HS_END);
    assign w_vs_raw = (r_sy >= C_VS_BEG) && (r_sy < C_VS_END);

    // Chain carries output levels so reset fills it with deasserted sync.
    assign w_chain_d = {
        w_hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
        w_vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
        w_de_raw
    };

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (C_CHAIN_RST)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_chain_d),
        .o_q   (w_chain_q)
    );

    assign vif.sx          = r_sx;
    assign vif.sy          = r_sy;
    assign vif.hsync       = w_chain_q[2];
    assign vif.vsync       = w_chain_q[1];
    assign vif.de          = w_chain_q[0];
    assign vif.frame_start = (r_sx == '0) && (r_sy == '0);

`ifdef VGA_BUFFER_SWAP_EN
    logic r_buf_sel;
    logic r_swap_ack;
    logic w_swap_pt;

    // Last cycle before vertical blanking; one such cycle per frame.
    assign w_swap_pt = w_h_end && (r_sy == C_VA - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_sel  <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_swap_ack <= w_swap_pt && vif.swap_req;
            if (w_swap_pt && vif.swap_req) begin
                r_buf_sel <= ~r_buf_sel;
            end
        end
    end

    assign vif.buf_sel  = r_buf_sel;
    assign vif.swap_ack = r_swap_ack;
`else
    logic w_unused_swap_req;
    assign w_unused_swap_req = vif.swap_req;
    assign vif.buf_sel       = 1'b0;
    assign vif.swap_ack      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-timing instance for line timing, shrunken
// instance (PIPE_DELAY=2, active-high sync) for frame and swap behaviour.
module tb_vga_timing;
    import vga_pkg::*;

`ifdef VGA_BUFFER_SWAP_EN
    localparam int SWAP_EN = 1;
`else
    localparam int SWAP_EN = 0;
`endif

    // Shrunken timing: H_TOTAL=28, V_TOTAL=17, frame=476 cycles
    localparam int SH_ACT = 16;
    localparam int SH_TOT = 28;
    localparam int SV_ACT = 10;
    localparam int SF_LEN = 476;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   e;

    vga_timing_if bd ();
    vga_timing_if bs ();

    vga_timing u_def (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (bd)
    );

    vga_timing #(
        .H_ACTIVE    (16),
        .H_FP        (4),
        .H_SYNC      (3),
        .H_BP        (5),
        .V_ACTIVE    (10),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (3),
        .SYNC_ACTIVE (1'b1),
        .PIPE_DELAY  (2)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go_to(input int n);
        while (e < n) tick();
    endtask

    task automatic wait_pos(input int y, input int x);
        int n;
        n = 0;
        while (!(bs.sy == y && bs.sx == x) && n < 600) begin
            tick();
            n++;
        end
        chk("wait_pos", 32'(bs.sy == y && bs.sx == x), 1);
    endtask

    task automatic run_win(input int n, output int acks,
                           output int asx, output int asy);
        acks = 0;
        asx  = 0;
        asy  = 0;
        repeat (n) begin
            tick();
            if (bs.swap_ack === 1'b1) begin
                acks++;
                asx = int'(bs.sx);
                asy = int'(bs.sy);
                bs.swap_req = 1'b0;
            end
        end
        bs.swap_req = 1'b0;
    endtask

    initial begin
        int n_de, n_hs, n_vs, n_fs;
        int fs0, fs1, vs_x, vs_y;
        logic vs_prev;
        int acks, asx, asy;

        total = 0;
        bad   = 0;
        e     = 0;
        rst_n = 1'b0;
        bd.swap_req = 1'b0;
        bs.swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_sx", 32'(bd.sx), 0);
        chk("rst_sy", 32'(bd.sy), 0);
        chk("rst_de", 32'(bd.de), 0);
        chk("rst_hs", 32'(bd.hsync), 1);
        chk("rst_vs", 32'(bd.vsync), 1);
        chk("rst_fs", 32'(bd.frame_start), 1);
        chk("rst_ack", 32'(bd.swap_ack), 0);
        chk("rst_buf", 32'(bd.buf_sel), 0);
        chk("rst_s_hs", 32'(bs.hsync), 0);
        chk("rst_s_vs", 32'(bs.vsync), 0);

        // Default timing, PIPE_DELAY=1
        rst_n = 1'b1;
        e = 0;
        tick();
        chk("e1_sx", 32'(bd.sx), 1);
        chk("e1_sy", 32'(bd.sy), 0);
        chk("e1_fs", 32'(bd.frame_start), 0);
        chk("e1_de", 32'(bd.de), 1);
        go_to(800);
        chk("de_last", 32'(bd.de), 1);
        go_to(801);
        chk("de_off", 32'(bd.de), 0);
        go_to(840);
        chk("hs_pre", 32'(bd.hsync), 1);
        go_to(841);
        chk("hs_on", 32'(bd.hsync), 0);
        go_to(888);
        chk("hs_end", 32'(bd.hsync), 0);
        go_to(889);
        chk("hs_off", 32'(bd.hsync), 1);
        go_to(975);
        chk("sx_975", 32'(bd.sx), 975);
        chk("sy_975", 32'(bd.sy), 0);
        go_to(976);
        chk("wrap_sx", 32'(bd.sx), 0);
        chk("wrap_sy", 32'(bd.sy), 1);
        chk("vs_line1", 32'(bd.vsync), 1);

        // Small instance from a fresh reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        e = 0;
        tick();
        chk("p2_de_e1", 32'(bs.de), 0);
        tick();
        chk("p2_de_e2", 32'(bs.de), 1);
        go_to(17);
        chk("p2_de_e17", 32'(bs.de), 1);
        go_to(18);
        chk("p2_de_e18", 32'(bs.de), 0);

        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        fs0 = -1; fs1 = -1; vs_x = -1; vs_y = -1;
        vs_prev = bs.vsync;
        for (int i = 0; i < 2 * SF_LEN; i++) begin
            tick();
            if (i < SF_LEN) begin
                if (bs.de === 1'b1) n_de++;
                if (bs.hsync === 1'b1) n_hs++;
                if (bs.vsync === 1'b1) n_vs++;
                if (bs.frame_start === 1'b1) n_fs++;
            end
            if (bs.frame_start === 1'b1) begin
                if (fs0 < 0) fs0 = e;
                else if (fs1 < 0) fs1 = e;
            end
            if (bs.vsync === 1'b1 && vs_prev === 1'b0 && vs_y < 0) begin
                vs_y = int'(bs.sy);
                vs_x = int'(bs.sx);
            end
            vs_prev = bs.vsync;
        end
        chk("frm_de", n_de, SH_ACT * SV_ACT);
        chk("frm_hs", n_hs, 3 * 17);
        chk("frm_vs", n_vs, 2 * SH_TOT);
        chk("frm_fs", n_fs, 1);
        chk("frm_period", fs1 - fs0, SF_LEN);
        chk("vs_rise_sy", vs_y, 12);
        chk("vs_rise_sx", vs_x, 2);

        // Held request from sy=3, dropped on ack
        wait_pos(3, 0);
        bs.swap_req = 1'b1;
        run_win(SF_LEN, acks, asx, asy);
        chk("a_acks", acks, SWAP_EN);
        chk("a_ack_sy", asy, SWAP_EN * SV_ACT);
        chk("a_ack_sx", asx, 0);
        chk("a_buf", 32'(bs.buf_sel), SWAP_EN);
        run_win(SF_LEN, acks, asx, asy);
        chk("a2_acks", acks, 0);
        chk("a2_buf", 32'(bs.buf_sel), SWAP_EN);

        // Pulse outside the swap point
        wait_pos(10, 5);
        bs.swap_req = 1'b1;
        tick();
        bs.swap_req = 1'b0;
        run_win(SF_LEN, acks, asx, asy);
        chk("b_acks", acks, 0);
        chk("b_buf", 32'(bs.buf_sel), SWAP_EN);

        // Pulse exactly at the swap point
        wait_pos(9, 27);
        bs.swap_req = 1'b1;
        tick();
        bs.swap_req = 1'b0;
        chk("c_ack", 32'(bs.swap_ack), SWAP_EN);
        chk("c_buf", 32'(bs.buf_sel), 0);
        chk("c_sy", 32'(bs.sy), 10);
        chk("c_sx", 32'(bs.sx), 0);
        tick();
        chk("c_ack_end", 32'(bs.swap_ack), 0);

        // Swap again, then async reset mid-line
        wait_pos(3, 0);
        bs.swap_req = 1'b1;
        run_win(SF_LEN, acks, asx, asy);
        chk("d_acks", acks, SWAP_EN);
        chk("d_buf", 32'(bs.buf_sel), SWAP_EN);
        wait_pos(6, 10);
        chk("d_pre_de", 32'(bs.de), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_sx", 32'(bs.sx), 0);
        chk("ar_sy", 32'(bs.sy), 0);
        chk("ar_de", 32'(bs.de), 0);
        chk("ar_hs", 32'(bs.hsync), 0);
        chk("ar_vs", 32'(bs.vsync), 0);
        chk("ar_fs", 32'(bs.frame_start), 1);
        chk("ar_buf", 32'(bs.buf_sel), 0);
        chk("ar_ack", 32'(bs.swap_ack), 0);
        chk("ar_def_hs", 32'(bd.hsync), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rr_sx", 32'(bs.sx), 1);
        chk("rr_sy", 32'(bs.sy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-clock timing generator for the 800x480 panel path. Produces the raw scan coordinates `sx`/`sy` that drive the colour stage's framebuffer addressing. Also produces `hsync`/`vsync`/`de` delayed to line up with the colour returned from synchronous framebuffer RAM. Optionally arbitrates a double-buffer swap at the start of vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 48, hsync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels); H_TOTAL = 976
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 13, vertical front porch (lines)
- `V_SYNC`, 3, vsync width (lines)
- `V_BP`, 32, vertical back porch (lines); V_TOTAL = 528
- `SYNC_ACTIVE`, 0, asserted level of `hsync`/`vsync`
- `PIPE_DELAY`, 1, cycles from `sx`/`sy` to valid `color` (RAM read latency); legal range 0..4

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: asynchronous, active-low reset
- `sx` out 10: horizontal counter, 0..H_TOTAL-1, undelayed
- `sy` out 10: vertical counter, 0..V_TOTAL-1, undelayed
- `hsync` out 1: horizontal sync, delayed PIPE_DELAY
- `vsync` out 1: vertical sync, delayed PIPE_DELAY
- `de` out 1: data enable, delayed PIPE_DELAY
- `frame_start` out 1: one-cycle pulse when sx=0, sy=0, undelayed
- `swap_req` in 1: renderer requests buffer swap (level)
- `swap_ack` out 1: one-cycle pulse, swap performed
- `buf_sel` out 1: framebuffer currently scanned out

## Operation
- `sx` increments every cycle. At H_TOTAL-1 it wraps to 0, and `sy` increments. `sy` wraps to 0 at V_TOTAL-1 when `sx` = H_TOTAL-1.
- Undelayed raw terms:
  - de_raw = (sx < H_ACTIVE) && (sy < V_ACTIVE)
  - hs_raw asserted for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC
  - vs_raw asserted for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC, on whole lines, changing when `sx` wraps
- Asserted sync output level = SYNC_ACTIVE; deasserted = ~SYNC_ACTIVE.
- `hsync`/`vsync`/`de` are the raw terms passed through a PIPE_DELAY-stage register chain. With PIPE_DELAY=0 they are combinational from the counters.
- Swap point is the cycle with sx=H_TOTAL-1 and sy=V_ACTIVE-1, i.e. the last cycle before vertical blanking:
  - If `swap_req`=1 at the swap point: `buf_sel` toggles on the following edge, and `swap_ack` is 1 for exactly that following cycle.
  - If `swap_req`=0: nothing happens.
  - `swap_req` sampled anywhere else is ignored.
  - At most one swap per frame.
  - A request still held high at the next frame's swap point swaps again; the renderer drops `swap_req` on `swap_ack`.
- Reset mid-frame: counters, delay chain, `buf_sel` and `swap_ack` all return to reset values immediately. Scanning restarts at (0,0) on the first edge after `rst_n` rises.

## Timing
- Reset values:
  - `sx`=0, `sy`=0, `de`=0, `swap_ack`=0, `buf_sel`=0
  - `hsync`=`vsync`=~SYNC_ACTIVE
  - `frame_start`=1 (counters at 0,0)
  - all delay-chain stages hold the deasserted values
- `sx`/`sy` are registered; `frame_start` is decoded from them.
- `de` at cycle t+PIPE_DELAY equals de_raw at cycle t.
- Frame period: 976*528 = 515328 cycles.
- `swap_ack` is registered: high on the cycle where sy=V_ACTIVE and sx=0.

## Configuration
- `VGA_BUFFER_SWAP_EN`
  - Defined: swap logic as above.
  - Undefined: `buf_sel` and `swap_ack` tied to 0, `swap_req` unused, and no swap flop is inferred.

## Structure
- Shared package `vga_pkg`:
  - default H/V timing constants and derived H_TOTAL/V_TOTAL localparams
  - MAX_SX=H_ACTIVE-1 and MAX_SY=V_ACTIVE-1, which the colour stage also uses
  - 10-bit coordinate typedef `coord_t`
- One sub-module, `vga_delay_line`:
  - parameterised width and depth
  - async active-low reset to a parameterised reset value
  - carries {hs_raw, vs_raw, de_raw}

## Test plan
- Reset held then released, defaults:
  - First edge gives sx=1, sy=0.
  - `hsync` first asserts (low) after PIPE_DELAY+840 edges, for 48 cycles.
  - `sx` wraps after 976 cycles.
- Full frame:
  - `de` high exactly 800*480=384000 cycles.
  - `vsync` low for 3*976=2928 cycles starting at sy=493.
  - `frame_start` repeats every 515328 cycles.
- PIPE_DELAY=2:
  - `de` rises exactly 2 cycles after sx=0, sy=0.
  - `de` falls 2 cycles after sx=800.
- Swap: `swap_req`=1 held from sy=100:
  - `swap_ack` pulses once at sy=480, sx=0.
  - `buf_sel` 0->1.
  - `swap_req` dropped on ack gives no further swap next frame.
- Edge request:
  - `swap_req` pulsed only at sy=480, sx=5 gives no swap.
  - `swap_req` pulsed only at sx=975, sy=479 gives a swap.
- Async reset asserted mid-line (sx=300, sy=200, `buf_sel`=1):
  - Outputs go to reset values without a clock edge.
  - `buf_sel`=0.
